bsg_manycore_gs_store_stage: RTL
================================

# bsg_manycore_gs_store_stage

Write-back stage of the gather/scatter DMA. It sits directly downstream of the gather engine's load-return path and buffers each returned load word tagged with its load ID. It issues one remote store per word to `dst_addr + load_id` on the destination tile. Once all stores are acknowledged, it writes 1 to the signal address to announce completion.

## Interface
Parameters:
- `x_cord_width_p`, "inv": X coordinate width.
- `y_cord_width_p`, "inv": Y coordinate width.
- `data_width_p`, 32: word width.
- `addr_width_p`, 32: word-address width.
- `load_id_width_p`, 11: load ID width; the ID is the word offset within the transfer.
- `max_out_credits_p`, 200: endpoint credit pool size.
- `buf_els_p`, 8: return-buffer depth (power of two, ≥2).

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  one-cycle pulse that starts a transfer; honoured only in IDLE.
- `dst_addr_i`  in  `addr_width_p`  destination base word address; latched on start.
- `dst_x_i`  in  `x_cord_width_p`  destination X coordinate; latched on start.
- `dst_y_i`  in  `y_cord_width_p`  destination Y coordinate; latched on start.
- `sig_addr_i`  in  `addr_width_p`  signal word address; latched on start.
- `sig_x_i`  in  `x_cord_width_p`  signal X coordinate; latched on start.
- `sig_y_i`  in  `y_cord_width_p`  signal Y coordinate; latched on start.
- `num_words_i`  in  `load_id_width_p+1`  word count; latched on start.
- `in_v_i`  in  1  returned load word valid.
- `in_data_i`  in  `data_width_p`  returned load word.
- `in_load_id_i`  in  `load_id_width_p`  returned load ID.
- `in_ready_o`  out  1  return word accepted when `in_v_i & in_ready_o`.
- `out_v_o`  out  1  store request valid.
- `out_addr_o`  out  `addr_width_p`  store word address.
- `out_data_o`  out  `data_width_p`  store payload.
- `out_mask_o`  out  `data_width_p/8`  byte mask, always all ones.
- `out_x_o`  out  `x_cord_width_p`  store target X coordinate.
- `out_y_o`  out  `y_cord_width_p`  store target Y coordinate.
- `out_ready_i`  in  1  endpoint accepts the packet.
- `out_credits_i`  in  `$clog2(max_out_credits_p+1)`  endpoint credits remaining.
- `busy_o`  out  1  state ≠ IDLE.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- Store fire: `out_v_o & out_ready_i`.
- `out_v_o` is never asserted when `out_credits_i == 0`.
- Return buffer:
  - `buf_els_p`-entry FIFO of {load_id, data}.
  - `in_ready_o = (state==STORE) & ~full`.
  - Enqueue and dequeue may happen in the same cycle when full: ready stays low that cycle (no bypass).
- State machine:
  - IDLE:
    - `start_i` latches all config, clears the store count, and moves to STORE.
    - If `num_words_i == 0`, moves to DRAIN instead.
  - STORE:
    - `out_v_o = ~empty & credits ≠ 0`.
    - `out_addr_o = dst_addr_r + zero-extended head load_id`, mod 2^`addr_width_p`.
    - `out_data_o` = head data; coordinates are dst.
    - On fire: pop the head and increment the count.
    - The fire that makes count == `num_words_r` moves to DRAIN.
  - DRAIN:
    - `out_v_o = 0`.
    - When `out_credits_i == max_out_credits_p`, moves to SIGNAL. This orders all data stores before the flag.
  - SIGNAL:
    - `out_v_o = (credits ≠ 0)`, with `out_addr_o = sig_addr_r`, `out_data_o = 1`, coordinates are sig.
    - On fire: moves to IDLE and sets `done_o` the next cycle.
- `start_i` outside IDLE is ignored; config registers are unchanged.
- Returned words arrive in any order; the load ID alone determines placement.
- Duplicate IDs are not detected. Each one counts toward `num_words`.
- `in_v_i` while `in_ready_o == 0` is back-pressure: upstream holds the word.

## Timing
- Reset (asynchronous, any state, mid-transfer included):
  - state IDLE, FIFO empty, count 0.
  - `out_v_o`, `in_ready_o`, `busy_o`, `done_o` = 0.
  - Config registers hold 0.
  - In-flight stores are abandoned; the endpoint's own reset covers credits.
- `start_i` at cycle T: `busy_o = 1` and `in_ready_o` can assert at T+1.
- Word enqueued at T: earliest store fire at T+1.
- Sustained throughput is one store per cycle while the FIFO is non-empty and credits are available.
- Last data fire at T: DRAIN at T+1. The DRAIN→SIGNAL check is registered, so SIGNAL is no earlier than T+2.
- Signal fire at T: IDLE and `done_o = 1` at T+1 only.
- A new `start_i` is accepted from T+1.

## Test plan
- Basic ordered transfer:
  - Stimulus: dst=0x100 at (2,1), sig=0x40 at (0,0), num=4; IDs 0..3 with data A0..A3; `out_ready_i = 1`, credits full.
  - Required: stores to 0x100..0x103 with A0..A3, then store 1 to 0x40 at (0,0), then a single `done_o` pulse.
- Out-of-order IDs: IDs 3,0,2,1 → each address equals 0x100+ID with matching data; signal issued only after the 4th store and after credits return to max.
- Back-pressure:
  - Stimulus: `out_ready_i = 0` while 10 words are offered.
  - Required: exactly 8 accepted and `in_ready_o` drops; releasing `out_ready_i` drains all 10 in ID order.
- Credit gating:
  - Stimulus: hold `out_credits_i` below max after the last store.
  - Required: stays in DRAIN, no signal; raising credits to max produces the signal store.
- Zero-length: num=0 → no data stores; signal store and `done_o` only.
- Reset mid-STORE:
  - Stimulus: assert `reset_i` after 2 of 4 stores.
  - Required: outputs 0 immediately; a new start with num=1 completes normally.

Source files
------------

// File: rtl/bsg_manycore_gs_store_stage.sv
// Gather/scatter write-back stage: buffers returned load words, stores each one to
// dst_addr + load_id, then writes 1 to the signal address once all stores are acknowledged.
module bsg_manycore_gs_store_stage #(
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 4,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int load_id_width_p   = 11,
    parameter int max_out_credits_p = 200,
    parameter int buf_els_p         = 8,
    localparam int credit_width_lp  = $clog2(max_out_credits_p+1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        start_i,
    input  logic [addr_width_p-1:0]     dst_addr_i,
    input  logic [x_cord_width_p-1:0]   dst_x_i,
    input  logic [y_cord_width_p-1:0]   dst_y_i,
    input  logic [addr_width_p-1:0]     sig_addr_i,
    input  logic [x_cord_width_p-1:0]   sig_x_i,
    input  logic [y_cord_width_p-1:0]   sig_y_i,
    input  logic [load_id_width_p:0]    num_words_i,

    input  logic                        in_v_i,
    input  logic [data_width_p-1:0]     in_data_i,
    input  logic [load_id_width_p-1:0]  in_load_id_i,
    output logic                        in_ready_o,

    output logic                        out_v_o,
    output logic [addr_width_p-1:0]     out_addr_o,
    output logic [data_width_p-1:0]     out_data_o,
    output logic [data_width_p/8-1:0]   out_mask_o,
    output logic [x_cord_width_p-1:0]   out_x_o,
    output logic [y_cord_width_p-1:0]   out_y_o,
    input  logic                        out_ready_i,
    input  logic [credit_width_lp-1:0]  out_credits_i,

    output logic                        busy_o,
    output logic                        done_o
);

    localparam int ptr_w_lp = $clog2(buf_els_p);

    localparam logic [1:0] IDLE_S   = 2'd0;
    localparam logic [1:0] STORE_S  = 2'd1;
    localparam logic [1:0] DRAIN_S  = 2'd2;
    localparam logic [1:0] SIGNAL_S = 2'd3;

    typedef struct packed {
        logic [load_id_width_p-1:0] id;
        logic [data_width_p-1:0]    data;
    } ret_s;

    logic [1:0]                  state_r;
    logic [addr_width_p-1:0]     dst_addr_r, sig_addr_r;
    logic [x_cord_width_p-1:0]   dst_x_r, sig_x_r;
    logic [y_cord_width_p-1:0]   dst_y_r, sig_y_r;
    logic [load_id_width_p:0]    num_words_r, count_r, count_inc;
    logic                        done_r;

    ret_s                        mem_r [buf_els_p];
    logic [ptr_w_lp:0]           wr_ptr_r, rd_ptr_r;
    logic                        full, empty, enq, deq, fire, cred_ok, start_ok;
    ret_s                        head;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[ptr_w_lp] != rd_ptr_r[ptr_w_lp])
                   & (wr_ptr_r[ptr_w_lp-1:0] == rd_ptr_r[ptr_w_lp-1:0]);
    assign head    = mem_r[rd_ptr_r[ptr_w_lp-1:0]];

    assign in_ready_o = (state_r == STORE_S) & ~full;
    assign enq        = in_v_i & in_ready_o;
    assign fire       = out_v_o & out_ready_i;
    assign deq        = fire & (state_r == STORE_S);
    assign cred_ok    = (out_credits_i != '0);
    assign start_ok   = start_i & (state_r == IDLE_S);
    assign count_inc  = count_r + 1'b1;

    assign out_mask_o = '1;
    assign busy_o     = (state_r != IDLE_S);
    assign done_o     = done_r;

    always_comb begin
        out_v_o    = 1'b0;
        out_addr_o = dst_addr_r + addr_width_p'(head.id);
        out_data_o = head.data;
        out_x_o    = dst_x_r;
        out_y_o    = dst_y_r;
        case (state_r)
            STORE_S:  out_v_o = ~empty & cred_ok;
            SIGNAL_S: begin
                out_v_o    = cred_ok;
                out_addr_o = sig_addr_r;
                out_data_o = data_width_p'(1);
                out_x_o    = sig_x_r;
                out_y_o    = sig_y_r;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= IDLE_S;
            dst_addr_r  <= '0;
            dst_x_r     <= '0;
            dst_y_r     <= '0;
            sig_addr_r  <= '0;
            sig_x_r     <= '0;
            sig_y_r     <= '0;
            num_words_r <= '0;
            count_r     <= '0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE_S: if (start_i) begin
                    dst_addr_r  <= dst_addr_i;
                    dst_x_r     <= dst_x_i;
                    dst_y_r     <= dst_y_i;
                    sig_addr_r  <= sig_addr_i;
                    sig_x_r     <= sig_x_i;
                    sig_y_r     <= sig_y_i;
                    num_words_r <= num_words_i;
                    count_r     <= '0;
                    state_r     <= (num_words_i == '0) ? DRAIN_S : STORE_S;
                end
                STORE_S: if (fire) begin
                    count_r <= count_inc;
                    if (count_inc == num_words_r) state_r <= DRAIN_S;
                end
                // Full credit pool means every data store has been acknowledged.
                DRAIN_S: if (out_credits_i == credit_width_lp'(max_out_credits_p))
                    state_r <= SIGNAL_S;
                SIGNAL_S: if (fire) begin
                    state_r <= IDLE_S;
                    done_r  <= 1'b1;
                end
                default: state_r <= IDLE_S;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (start_ok) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (enq) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (deq) rd_ptr_r <= rd_ptr_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r[ptr_w_lp-1:0]] <= '{id: in_load_id_i, data: in_data_i};
    end

endmodule
